// File: rtl/fp_pkg.sv
// Shared constants and encodings for the FP execution slot (divider and multiplier).
package fp_pkg;

  localparam int          EXP_BIAS        = 127;
  localparam int          EXP_MAX         = 255;
  localparam logic [31:0] NAN_PATTERN_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SPECIAL,
    DIV,
    NORM,
    DONE
  } fp_state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Splits an IEEE-754 single into class, sign, exponent and 24-bit significand.
// Denormals are reported as zero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] word,
  output fp_class_t   cls,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] sig
);

  assign sign = word[31];
  assign exp  = word[30:23];
  assign sig  = {1'b1, word[22:0]};

  always_comb begin
    cls = NORMAL;
    if (exp == 8'd0)
      cls = ZERO;
    else if (exp == 8'hFF)
      cls = (word[22:0] != 23'd0) ? NAN : INF;
  end

endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider: restoring division, one quotient bit per cycle,
// truncating rounding, denormals flushed to zero.
module fp_div
  import fp_pkg::*;
#(
  parameter logic [31:0] NAN_PATTERN = NAN_PATTERN_DEF,
  parameter int          QBITS       = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam int CNT_W = $clog2(QBITS);

  fp_state_t             state;
  logic [31:0]           a_r, b_r;
  logic [24:0]           rem;
  logic [QBITS-1:0]      q;
  logic [CNT_W-1:0]      cnt;
  logic signed [9:0]     exp_r;
  logic [31:0]           res_nxt;
  logic                  dbz_nxt, inv_nxt;

  fp_class_t   cls_a, cls_b;
  logic        sgn_a, sgn_b;
  logic [7:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;

  fp_classify u_cls_a (.word(a_r), .cls(cls_a), .sign(sgn_a), .exp(exp_a), .sig(sig_a));
  fp_classify u_cls_b (.word(b_r), .cls(cls_b), .sign(sgn_b), .exp(exp_b), .sig(sig_b));

  logic sgn;
  logic is_special;
  assign sgn        = sgn_a ^ sgn_b;
  assign is_special = (cls_a != NORMAL) || (cls_b != NORMAL);

  // Restoring step: compare the 25-bit remainder against the zero-extended divisor.
  logic [24:0] divisor;
  logic [24:0] diff;
  logic        q_bit;
  assign divisor = {1'b0, sig_b};
  assign diff    = rem - divisor;
  assign q_bit   = (rem >= divisor);

  logic [31:0] spec_res;
  logic        spec_dbz, spec_inv;
  always_comb begin
    spec_res = {sgn, 31'd0};
    spec_dbz = 1'b0;
    spec_inv = 1'b0;
    if (cls_a == NAN || cls_b == NAN) begin
      spec_res = NAN_PATTERN;
    end else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
      spec_res = NAN_PATTERN;
      spec_inv = 1'b1;
    end else if (cls_a == INF) begin
      spec_res = {sgn, 8'hFF, 23'd0};
    end else if (cls_b == INF) begin
      spec_res = {sgn, 31'd0};
    end else if (cls_b == ZERO) begin
      spec_res = {sgn, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end
  end

  // Ma/Mb lies in [0.5, 2): the leading one is in one of the top two quotient bits.
  logic signed [9:0] norm_e;
  logic [22:0]       norm_mant;
  logic [31:0]       norm_res;
  always_comb begin
    if (q[QBITS-1]) begin
      norm_e    = exp_r;
      norm_mant = q[QBITS-2 -: 23];
    end else begin
      norm_e    = exp_r - 10'sd1;
      norm_mant = q[QBITS-3 -: 23];
    end
    if (norm_e >= 10'(EXP_MAX))
      norm_res = {sgn, 8'hFF, 23'd0};
    else if (norm_e <= 10'sd0)
      norm_res = {sgn, 31'd0};
    else
      norm_res = {sgn, norm_e[7:0], norm_mant};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 32'd0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !busy && !done) begin
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (is_special) begin
            state <= SPECIAL;
          end else begin
            rem   <= {1'b0, sig_a};
            q     <= '0;
            cnt   <= CNT_W'(QBITS - 1);
            exp_r <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'(EXP_BIAS);
            state <= DIV;
          end
        end
        SPECIAL: begin
          res_nxt <= spec_res;
          dbz_nxt <= spec_dbz;
          inv_nxt <= spec_inv;
          state   <= DONE;
        end
        DIV: begin
          rem <= q_bit ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
          q   <= {q[QBITS-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= NORM;
        end
        NORM: begin
          res_nxt <= norm_res;
          dbz_nxt <= 1'b0;
          inv_nxt <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          result      <= res_nxt;
          div_by_zero <= dbz_nxt;
          invalid     <= inv_nxt;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed self-checking bench for fp_div: arithmetic, specials, range limits,
// handshake and mid-operation reset.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    logic        div_by_zero, invalid;

    int tests = 0;
    int fails = 0;

    fp_div dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp_v);
        end
    endtask

    // Pulses start for one edge, then counts edges until done is seen.
    task automatic run(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] er,
                       input logic edbz, input logic einv, input int elat, input string tag);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, elat);
        chk({tag, " result"}, result, er);
        chk({tag, " div_by_zero"}, div_by_zero, edbz);
        chk({tag, " invalid"}, invalid, einv);
        @(posedge clk); #1;
    endtask

    initial begin
        int  n;
        bit  all_busy;
        bit  saw_done;

        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {div_by_zero, invalid}, 2'b00);
        @(negedge clk); rst = 1'b0;

        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28, "6/2");
        run(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 1'b0, 28, "-6/2");
        run(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 28, "1/3");

        run(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 3, "1/0");
        run(32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 3, "0/0");
        run(32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 3, "inf/inf");
        run(32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, 3, "2/inf");
        run(32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, "nan/1");
        run(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, 3, "-inf/2");

        run(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 1'b0, 28, "overflow");
        run(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 28, "underflow");
        run(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 3, "denormal");

        // Second start mid-divide with new operands must be ignored.
        @(negedge clk);
        a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        all_busy = 1'b1;
        n = 0;
        while (!done && n < 60) begin
            if (n == 5) begin
                a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!busy) all_busy = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("ignore start latency", n, 28);
        chk("ignore start busy", all_busy, 1'b1);
        chk("ignore start result", result, 32'h4040_0000);
        @(posedge clk); #1;

        // Start held high: accepted again on the edge after the done cycle.
        @(negedge clk);
        a = 32'hC0C0_0000; b = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        a = 32'h3F80_0000; b = 32'h4040_0000;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b first latency", n, 28);
        chk("b2b first result", result, 32'hC040_0000);
        @(posedge clk); #1;
        chk("b2b idle busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("b2b reaccept busy", busy, 1'b1);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b second latency", n, 28);
        chk("b2b second result", result, 32'h3EAA_AAAA);
        @(posedge clk); #1;

        // Reset in the middle of DIV aborts the operation.
        @(negedge clk);
        a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", saw_done, 1'b0);
        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28, "after reset 6/2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Iterative IEEE-754 single-precision divider for the VLIW FP execution slot. It is the counterpart of the floating-point multiplier.
- Computes result = a / b using restoring division, one quotient bit per cycle.
- Uses a start/busy/done handshake so the issue logic can stall the slot while a divide is in flight.
- Rounding is truncation, denormals are flushed to zero, and NaN encoding matches the multiplier.

Parameters:
- NAN_PATTERN, 32'hFFFFFFFF: word returned for any NaN result (the multiplier's NaN encoding).
- QBITS, 25: quotient bits generated; also the number of DIV iterations.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  32  dividend (IEEE-754 single).
- b  in  32  divisor (IEEE-754 single).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  quotient; held stable until the next accepted start.
- div_by_zero  out  1  valid with done; finite nonzero a / zero b.
- invalid  out  1  valid with done; 0/0 or inf/inf.

Behaviour:
- Reset
  - rst=1 forces state IDLE with busy=0, done=0, result=0, div_by_zero=0, invalid=0.
  - Reset mid-operation aborts the divide; no done is produced.
- Handshake
  - Start is accepted when start=1 and busy=0 and done=0.
  - On acceptance, a and b are registered. Later changes on a/b have no effect.
  - start while busy, or in the done cycle, is ignored.
  - Flags and result update only in the done cycle.
- Input classification (on registered operands)
  - E==0: zero, regardless of mantissa (denormal flush).
  - E==255 with M!=0: NaN.
  - E==255 with M==0: inf.
  - Otherwise: normal, with significand {1,M} (24 bits).
  - Result sign s = sa ^ sb.
- State machine: IDLE -> LOAD -> (SPECIAL | DIV) -> NORM -> DONE -> IDLE.
  - LOAD: classify operands.
    - If special, go to SPECIAL.
    - Else: R <= {1'b0,Ma}, q <= 0, cnt <= QBITS-1, exp <= Ea - Eb + 127 (10-bit signed).
  - SPECIAL: compute the special result, then go to DONE. Total latency is 3 cycles (done asserted 3 cycles after the acceptance edge).
  - DIV: each cycle, if R >= Mb then q_bit=1 and R <= (R-Mb)<<1, else q_bit=0 and R <= R<<1. Shift q_bit into q. Go to NORM when cnt==0.
  - NORM:
    - If q[24]=1: mant = q[23:1], e = exp.
    - Else: mant = q[22:0], e = exp-1.
    - If e >= 255: signed inf. If e <= 0: signed zero. Otherwise {s, e[7:0], mant}.
  - DONE: drive result and flags, done=1 for exactly one cycle, busy=0 next cycle.
  - Normal latency: done 1 (LOAD) + 25 (DIV) + 1 (NORM) + 1 = 28 cycles after the acceptance edge.
- Special results (priority order)
  - a or b NaN: NAN_PATTERN, invalid=0.
  - 0/0 or inf/inf: NAN_PATTERN, invalid=1.
  - inf/finite: {s, 8'hFF, 0}.
  - finite/inf: {s, 31'b0}.
  - nonzero/0: {s, 8'hFF, 0}, div_by_zero=1.
  - 0/nonzero: {s, 31'b0}.
- Arithmetic
  - Ma/Mb lies in [0.5, 2), so exactly one of q[24] or q[23] is set.
  - Remainder register is 25 bits; the subtract compares 25-bit R against zero-extended Mb.
  - Extra low quotient bits are truncated; there is no sticky or round bit.

Decomposition:
- Package fp_pkg: constants EXP_BIAS=127, EXP_MAX=255, NAN_PATTERN default, state encoding (IDLE, LOAD, SPECIAL, DIV, NORM, DONE), and an fp_class enum (ZERO, NORMAL, INF, NAN). The multiplier reuses the same package.
- One combinational sub-module, fp_classify: 32-bit word in, class plus sign/exp/significand out. Instantiated twice.
- Datapath and FSM stay in fp_div.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> result 0x40400000, done exactly 28 cycles after start, flags 0. Repeat with -6.0 (a=0xC0C00000) -> 0xC0400000.
- 1.0/3.0: a=0x3F800000, b=0x40400000 -> 0x3EAAAAAA (truncated); q[24]=0 path.
- Specials, each with done 3 cycles after start:
  - 1.0/+0: a=0x3F800000, b=0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0/0 -> 0xFFFFFFFF, invalid=1.
  - 0x7F800000 / 0x7F800000 -> 0xFFFFFFFF, invalid=1.
  - 0x40000000 / 0x7F800000 -> 0x00000000.
- Range limits:
  - Overflow 0x7F000000 / 0x3E800000 -> 0x7F800000.
  - Underflow 0x00800000 / 0x40000000 -> 0x00000000.
  - Denormal a=0x00000001 / 1.0 -> 0x00000000.
- Handshake: pulse start again 5 cycles into a divide with different a/b -> ignored; result is from the first operands and busy stays high throughout. Back-to-back: start held high gives a new acceptance the cycle after done.
- Reset at DIV cycle 10 -> next cycle busy=0, done=0, result=0; no done pulse follows. A fresh 6.0/2.0 afterwards returns 0x40400000.
